// File: rtl/i2s_dma_pkg.sv
// i2s_dma_pkg: FSM state encoding and idle-flush timeout shared by the I2S DMA controller files.
package i2s_dma_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, LOAD, WRITE} state_t;
  localparam logic [15:0] FLUSH_TIMEOUT = 16'hFFFF;
endpackage

// File: rtl/i2s_dma_ctrl_if.sv
// i2s_dma_ctrl_if: FIFO read port and memory write handshake between the DMA (master) and the system (slave).
interface i2s_dma_ctrl_if #(
  parameter int AW = 4,
  parameter int MAW = 16
);
  logic [AW-1:0]  fifo_level;
  logic           fifo_empty;
  logic [31:0]    fifo_rdata;
  logic           fifo_rd;
  logic           mem_req;
  logic [MAW-1:0] mem_addr;
  logic [31:0]    mem_wdata;
  logic           mem_ack;
  modport master(input fifo_level, fifo_empty, fifo_rdata, mem_ack, output fifo_rd, mem_req, mem_addr, mem_wdata);
  modport slave(output fifo_level, fifo_empty, fifo_rdata, mem_ack, input fifo_rd, mem_req, mem_addr, mem_wdata);
endinterface

// File: rtl/i2s_dma_addr_gen.sv
// i2s_dma_addr_gen: buffer pointer and per-pass word count with half-buffer and wrap pulses.
module i2s_dma_addr_gen
  import i2s_dma_pkg::*;
#(
  parameter int MAW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic           ack,
  input  logic [MAW-1:0] base,
  input  logic [MAW-1:0] len,
  input  logic           circ,
  output logic [MAW-1:0] addr,
  output logic [MAW-1:0] cnt,
  output logic [MAW-1:0] rem,
  output logic           half,
  output logic           wrap,
  output logic           fin
);
  logic [MAW-1:0] base_q, len_q, nxt;
  logic           circ_q, last, reload;
  assign nxt    = cnt + MAW'(1);
  assign last   = nxt == len_q;
  assign reload = last && circ_q;
  assign rem    = len_q - cnt;
  assign fin    = last && !circ_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      len_q  <= '0;
      circ_q <= 1'b0;
      addr   <= '0;
      cnt    <= '0;
      half   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      half <= ack && nxt == (len_q >> 1);
      wrap <= ack && reload;
      if (init) begin
        base_q <= base;
        len_q  <= len;
        circ_q <= circ;
        addr   <= base;
        cnt    <= '0;
      end else if (ack) begin
        addr <= reload ? base_q : addr + MAW'(1);
        cnt  <= reload ? '0 : nxt;
      end
    end
  end
endmodule

// File: rtl/i2s_dma_ctrl.sv
// i2s_dma_ctrl: drains an I2S FIFO into a linear or circular memory buffer in bursts.
// Define I2S_DMA_CTRL_FLUSH_EN to flush a partial burst after a long idle wait.
module i2s_dma_ctrl
  import i2s_dma_pkg::*;
#(
  parameter int AW = 4,
  parameter int MAW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic           circular,
  input  logic [MAW-1:0] base_addr,
  input  logic [MAW-1:0] buf_len,
  input  logic [AW-1:0]  burst_len,
  i2s_dma_ctrl_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           half,
  output logic           wrap,
  output logic [MAW-1:0] words_cnt
);
  state_t         state;
  logic [AW-1:0]  bcnt, eff, blen;
  logic [MAW-1:0] rem;
  logic [31:0]    wdata;
  logic           fin, stop_q, init, ack, trig, flush;
  assign eff          = burst_len == '0 ? AW'(1) : burst_len;
  assign blen         = rem < MAW'(eff) ? AW'(rem) : eff;
  assign trig         = bus.fifo_level >= eff || MAW'(bus.fifo_level) >= rem;
  assign init         = state == IDLE && start && buf_len != '0;
  assign ack          = state == WRITE && bus.mem_ack;
  assign bus.fifo_rd  = state == LOAD && !bus.fifo_empty && !stop;
  assign bus.mem_req  = state == WRITE;
  assign bus.mem_wdata = wdata;
  assign busy         = state != IDLE;
`ifdef I2S_DMA_CTRL_FLUSH_EN
  logic [15:0] idle;
  assign flush = idle == FLUSH_TIMEOUT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle <= '0;
    else idle <= state == WAIT && !bus.fifo_empty && !trig && !flush && !stop ? idle + 16'd1 : '0;
  end
`else
  assign flush = 1'b0;
`endif
  i2s_dma_addr_gen #(.MAW(MAW)) u_addr (
    .clk (clk),
    .rst (rst),
    .init(init),
    .ack (ack),
    .base(base_addr),
    .len (buf_len),
    .circ(circular),
    .addr(bus.mem_addr),
    .cnt (words_cnt),
    .rem (rem),
    .half(half),
    .wrap(wrap),
    .fin (fin)
  );
  // A stop seen during WRITE is remembered so the handshake can finish first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      bcnt   <= '0;
      wdata  <= '0;
      done   <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (init) begin
          state  <= WAIT;
          stop_q <= 1'b0;
        end
        WAIT: if (stop) state <= IDLE;
        else if (trig || flush) begin
          state <= LOAD;
          bcnt  <= trig ? blen : bus.fifo_level;
        end
        LOAD: if (stop) state <= IDLE;
        else if (!bus.fifo_empty) begin
          wdata <= bus.fifo_rdata;
          state <= WRITE;
        end
        WRITE: begin
          stop_q <= stop_q | stop;
          if (bus.mem_ack) begin
            bcnt  <= bcnt - AW'(1);
            done  <= fin;
            state <= fin || stop || stop_q ? IDLE : bcnt != AW'(1) ? LOAD : WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2s_dma_ctrl.sv
// tb_i2s_dma_ctrl: table-driven transfers with a FIFO/memory model and address/data scoreboard.
module tb_i2s_dma_ctrl;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, circular = 1'b0;
  logic [15:0] base_addr = '0, buf_len = '0;
  logic [3:0]  burst_len = '0;
  logic        busy, done, half, wrap;
  logic [15:0] words_cnt;
  i2s_dma_ctrl_if #(.AW(4), .MAW(16)) bus();
  i2s_dma_ctrl #(.AW(4), .MAW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .circular(circular),
    .base_addr(base_addr), .buf_len(buf_len), .burst_len(burst_len), .bus(bus),
    .busy(busy), .done(done), .half(half), .wrap(wrap), .words_cnt(words_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  logic        push = 1'b0;
  logic [31:0] pdata = '0;
  logic [31:0] fmem [256];
  logic [7:0]  wp, rp, lvl;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (bus.fifo_rd && wp != rp) rp <= rp + 8'd1;
      if (push) begin
        fmem[wp] <= pdata;
        wp <= wp + 8'd1;
      end
    end
  end
  assign lvl = wp - rp;
  assign bus.fifo_empty = wp == rp;
  assign bus.fifo_level = lvl > 8'd15 ? 4'd15 : lvl[3:0];
  assign bus.fifo_rdata = fmem[rp];
  logic ack_tie = 1'b0, ack_man = 1'b0;
  int   ack_dly = 0, wcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else wcnt <= bus.mem_req && !bus.mem_ack ? wcnt + 1 : 0;
  end
  assign bus.mem_ack = ack_tie | ack_man | (ack_dly != 0 && bus.mem_req && wcnt >= ack_dly);
  typedef struct packed {logic [15:0] a; logic [31:0] d;} sb_t;
  sb_t sb[$];
  sb_t e;
  int checks = 0, errors = 0;
  int n_done = 0, n_half = 0, n_wrap = 0, n_rd = 0, n_act = 0, n_bf = 0;
  logic prev_req, prev_ack, prev_rd, prev_busy;
  logic [15:0] p_addr;
  logic [31:0] p_data;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, x);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
      prev_rd = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (bus.fifo_rd) begin
        n_rd++;
        chk("rd_empty", bus.fifo_empty, 0);
        chk("rd_double", prev_rd, 0);
      end
      if (bus.fifo_rd || bus.mem_req) n_act++;
      if (bus.mem_req && prev_req && !prev_ack) begin
        chk("addr_hold", bus.mem_addr, p_addr);
        chk("data_hold", bus.mem_wdata, p_data);
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra actual addr=%0h required none", bus.mem_addr);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", bus.mem_addr, e.a);
          chk("wr_data", bus.mem_wdata, e.d);
        end
      end
      if (done) begin
        n_done++;
        chk("done_cnt", words_cnt, buf_len);
      end
      if (half) begin
        n_half++;
        chk("half_cnt", words_cnt, buf_len >> 1);
      end
      if (wrap) begin
        n_wrap++;
        chk("wrap_cnt", words_cnt, 0);
      end
      if (prev_busy && !busy) n_bf++;
      prev_req = bus.mem_req;
      prev_ack = bus.mem_ack;
      prev_rd = bus.fifo_rd;
      prev_busy = busy;
      p_addr = bus.mem_addr;
      p_data = bus.mem_wdata;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    push = 1'b0;
    ack_tie = 1'b0;
    ack_man = 1'b0;
    ack_dly = 0;
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic push_word(input int k, input bit x);
    pdata = $urandom;
    push = 1'b1;
    if (x) sb.push_back({16'(base_addr + k % buf_len), pdata});
    tick();
    push = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_req();
    int t = 0;
    while (!bus.mem_req && t < 50) begin
      tick();
      t++;
    end
    chk("req_seen", bus.mem_req, 1);
  endtask
  typedef struct {
    logic [15:0] base, len;
    logic [3:0] burst;
    logic circ;
    int pre, nw, dly, e_done, e_half, e_wrap, e_act;
  } vec_t;
  vec_t vt[7];
  task automatic run(input int id, input vec_t v);
    int d0, h0, w0, r0, a0, b0, t;
    do_reset();
    base_addr = v.base;
    buf_len = v.len;
    burst_len = v.burst;
    circular = v.circ;
    ack_tie = v.dly == 0;
    ack_dly = v.dly;
    d0 = n_done; h0 = n_half; w0 = n_wrap; r0 = n_rd; a0 = n_act; b0 = n_bf;
    for (int k = 0; k < v.pre; k++) push_word(k, 1);
    pulse_start();
    for (int k = v.pre; k < v.nw; k++) begin
      push_word(k, 1);
      tick();
    end
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    chk($sformatf("v%0d_drain", id), sb.size(), 0);
    repeat (3) tick();
    chk($sformatf("v%0d_busy", id), busy, v.circ);
    chk($sformatf("v%0d_words_cnt", id), words_cnt, v.circ ? v.nw % v.len : v.len);
    chk($sformatf("v%0d_busy_fall", id), n_bf - b0, v.e_done);
    if (v.circ) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      chk($sformatf("v%0d_stop_idle", id), busy, 0);
    end
    chk($sformatf("v%0d_done", id), n_done - d0, v.e_done);
    chk($sformatf("v%0d_half", id), n_half - h0, v.e_half);
    chk($sformatf("v%0d_wrap", id), n_wrap - w0, v.e_wrap);
    chk($sformatf("v%0d_rd", id), n_rd - r0, v.nw);
    chk($sformatf("v%0d_act", id), n_act - a0, v.e_act);
  endtask
  initial begin
    int d0, r0, t;
    vt[0] = '{16'h0100, 16'd8, 4'd4, 1'b0, 8, 8, 0, 1, 1, 0, 16};
    vt[1] = '{16'h0100, 16'd4, 4'd2, 1'b1, 0, 10, 0, 0, 3, 2, 20};
    vt[2] = '{16'h0200, 16'd6, 4'd3, 1'b0, 6, 6, 3, 1, 1, 0, 30};
    vt[3] = '{16'h0040, 16'd3, 4'd0, 1'b0, 0, 3, 0, 1, 1, 0, 6};
    vt[4] = '{16'h03F0, 16'd5, 4'd8, 1'b0, 5, 5, 0, 1, 1, 0, 10};
    vt[5] = '{16'h03F0, 16'd5, 4'd8, 1'b0, 0, 5, 0, 1, 1, 0, 10};
    vt[6] = '{16'hFFFF, 16'd2, 4'd1, 1'b0, 2, 2, 1, 1, 1, 0, 6};
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_half", half, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_rd", bus.fifo_rd, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_cnt", words_cnt, 0);
    for (int i = 0; i < 7; i++) run(i, vt[i]);
    do_reset();
    base_addr = 16'h0100;
    buf_len = 16'd0;
    burst_len = 4'd1;
    pulse_start();
    tick();
    chk("len0_busy", busy, 0);
    buf_len = 16'd4;
    burst_len = 4'd2;
    ack_tie = 1'b1;
    d0 = n_done;
    pulse_start();
    tick();
    base_addr = 16'h0500;
    buf_len = 16'd2;
    pulse_start();
    chk("rebusy_busy", busy, 1);
    base_addr = 16'h0100;
    buf_len = 16'd4;
    for (int k = 0; k < 4; k++) push_word(k, 1);
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    repeat (3) tick();
    chk("rebusy_drain", sb.size(), 0);
    chk("rebusy_done", n_done - d0, 1);
    chk("rebusy_cnt", words_cnt, 4);
    do_reset();
    base_addr = 16'h0180;
    buf_len = 16'd8;
    burst_len = 4'd2;
    d0 = n_done;
    r0 = n_rd;
    push_word(0, 1);
    push_word(1, 0);
    pulse_start();
    wait_req();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("sw_hold_req", bus.mem_req, 1);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("sw_idle", busy, 0);
    tick();
    chk("sw_written", sb.size(), 0);
    chk("sw_cnt", words_cnt, 1);
    chk("sw_no_done", n_done - d0, 0);
    chk("sw_rd", n_rd - r0, 1);
    do_reset();
    base_addr = 16'h01C0;
    buf_len = 16'd1;
    burst_len = 4'd1;
    d0 = n_done;
    push_word(0, 1);
    pulse_start();
    wait_req();
    stop = 1'b1;
    ack_man = 1'b1;
    tick();
    stop = 1'b0;
    ack_man = 1'b0;
    tick();
    chk("sf_idle", busy, 0);
    chk("sf_done", n_done - d0, 1);
    chk("sf_written", sb.size(), 0);
    do_reset();
    buf_len = 16'd4;
    burst_len = 4'd2;
    d0 = n_done;
    pulse_start();
    tick();
    chk("swait_busy", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("swait_idle", busy, 0);
    tick();
    chk("swait_no_done", n_done - d0, 0);
    do_reset();
    base_addr = 16'h0100;
    buf_len = 16'd4;
    burst_len = 4'd1;
    push_word(0, 1);
    pulse_start();
    wait_req();
    chk("ar_addr_pre", bus.mem_addr, 16'h0100);
    #3 rst = 1'b1;
    #1;
    chk("ar_req", bus.mem_req, 0);
    chk("ar_busy", busy, 0);
    chk("ar_addr", bus.mem_addr, 0);
    chk("ar_wdata", bus.mem_wdata, 0);
    do_reset();
    base_addr = 16'h0300;
    buf_len = 16'd8;
    burst_len = 4'd8;
    ack_tie = 1'b1;
    r0 = n_rd;
`ifdef I2S_DMA_CTRL_FLUSH_EN
    for (int k = 0; k < 3; k++) push_word(k, 1);
    pulse_start();
    t = 0;
    while (sb.size() != 0 && t < 70000) begin
      tick();
      t++;
    end
    chk("flush_drain", sb.size(), 0);
    chk("flush_time", t >= 65530 && t <= 65560, 1);
    chk("flush_cnt", words_cnt, 3);
    chk("flush_rd", n_rd - r0, 3);
`else
    for (int k = 0; k < 3; k++) push_word(k, 0);
    pulse_start();
    repeat (300) tick();
    chk("noflush_rd", n_rd - r0, 0);
    chk("noflush_busy", busy, 1);
`endif
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
